// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one 16x8 memory port among clear, loader, fetch and
//               data-path requesters (clr > ld > round-robin if/dp).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int AW         = 4,
  parameter int DW         = 8,
  parameter int RD_TIMEOUT = 8
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clr_req_i,
  output logic          clr_done_o,
  input  logic          ld_req_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [DW-1:0] ld_wdata_i,
  output logic          ld_done_o,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_done_o,
  input  logic          dp_req_i,
  input  logic          dp_we_i,
  input  logic [AW-1:0] dp_addr_i,
  input  logic [DW-1:0] dp_wdata_i,
  output logic [DW-1:0] dp_rdata_o,
  output logic          dp_done_o,
  output logic          rd_err_o,
  output logic          busy_o,
  output logic          mem_rw_o,
  output logic          mem_clr_o,
  output logic [AW-1:0] mem_address_o,
  output logic [DW-1:0] mem_data_in_o,
  input  logic [DW-1:0] mem_data_out_i,
  input  logic          mem_out_valid_i
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_CLR     = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [1:0] OWN_CLR = 2'd0;
  localparam logic [1:0] OWN_LD  = 2'd1;
  localparam logic [1:0] OWN_IF  = 2'd2;
  localparam logic [1:0] OWN_DP  = 2'd3;

  localparam int TW = $clog2(RD_TIMEOUT + 1);

  logic [2:0]    state_q, state_d;
  logic [1:0]    owner_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [TW-1:0] tmo_q;
  logic          err_q;
  logic          last_dp_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] dp_rdata_q;

  logic          win_vld;
  logic [1:0]    win_own;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic          win_we;
  logic          tmo_last;
  logic          rd_end;

  assign tmo_last = (tmo_q == TW'(RD_TIMEOUT - 1));
  assign rd_end   = mem_out_valid_i || tmo_last;

  // last_dp_q set means dp was served last, so fetch wins a tie
  always_comb begin : arb
    win_vld   = 1'b1;
    win_own   = OWN_CLR;
    win_addr  = '0;
    win_wdata = '0;
    win_we    = 1'b0;
    if (clr_req_i) begin
      win_own = OWN_CLR;
    end else if (ld_req_i) begin
      win_own   = OWN_LD;
      win_addr  = ld_addr_i;
      win_wdata = ld_wdata_i;
      win_we    = 1'b1;
    end else if (if_req_i && (!dp_req_i || last_dp_q)) begin
      win_own  = OWN_IF;
      win_addr = if_addr_i;
    end else if (dp_req_i) begin
      win_own   = OWN_DP;
      win_addr  = dp_addr_i;
      win_wdata = dp_wdata_i;
      win_we    = dp_we_i;
    end else begin
      win_vld = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin : fsm_state
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          if (win_own == OWN_CLR) state_d = S_CLR;
          else if (win_we)        state_d = S_WR;
          else                    state_d = S_RD_WAIT;
        end
      end
      S_WR:      state_d = S_DONE;
      S_CLR:     state_d = S_DONE;
      S_RD_WAIT: if (rd_end) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin : datapath
    if (reset_i) begin
      owner_q    <= OWN_CLR;
      addr_q     <= '0;
      wdata_q    <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      last_dp_q  <= 1'b1;
      if_rdata_q <= '0;
      dp_rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            owner_q <= win_own;
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
            tmo_q   <= '0;
            err_q   <= 1'b0;
          end
        end
        S_RD_WAIT: begin
          // Read data lands in the owner's holding register on entry to DONE
          if (rd_end) begin
            err_q <= !mem_out_valid_i;
            if (owner_q == OWN_IF) if_rdata_q <= mem_out_valid_i ? mem_data_out_i : '0;
            else                   dp_rdata_q <= mem_out_valid_i ? mem_data_out_i : '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_DONE: begin
          if (owner_q == OWN_IF)      last_dp_q <= 1'b0;
          else if (owner_q == OWN_DP) last_dp_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin : fsm_out
    busy_o        = (state_q != S_IDLE);
    mem_rw_o      = 1'b0;
    mem_clr_o     = 1'b0;
    mem_address_o = '0;
    mem_data_in_o = '0;
    clr_done_o    = 1'b0;
    ld_done_o     = 1'b0;
    if_done_o     = 1'b0;
    dp_done_o     = 1'b0;
    rd_err_o      = 1'b0;
    case (state_q)
      S_WR: begin
        mem_rw_o      = 1'b1;
        mem_address_o = addr_q;
        mem_data_in_o = wdata_q;
      end
      S_RD_WAIT: mem_address_o = addr_q;
      S_CLR:     mem_clr_o     = 1'b1;
      S_DONE: begin
        rd_err_o = err_q;
        case (owner_q)
          OWN_CLR: clr_done_o = 1'b1;
          OWN_LD:  ld_done_o  = 1'b1;
          OWN_IF:  if_done_o  = 1'b1;
          default: dp_done_o  = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  assign if_rdata_o = if_rdata_q;
  assign dp_rdata_o = dp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a transaction-level
//               reference model and a responding memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int RD_TIMEOUT = 8;
  localparam int NC = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          clr_req, clr_done, ld_req, ld_done, if_req, if_done;
  logic          dp_req, dp_we, dp_done, rd_err, busy, mem_rw, mem_clr;
  logic [AW-1:0] ld_addr, if_addr, dp_addr, mem_address;
  logic [DW-1:0] ld_wdata, dp_wdata, if_rdata, dp_rdata, mem_data_in;
  logic [DW-1:0] mem_data_out = '0;
  logic          mem_out_valid = 1'b0;

  mem_arbiter #(.AW(AW), .DW(DW), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk_i(clk), .reset_i(reset),
    .clr_req_i(clr_req), .clr_done_o(clr_done),
    .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata), .ld_done_o(ld_done),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_done_o(if_done),
    .dp_req_i(dp_req), .dp_we_i(dp_we), .dp_addr_i(dp_addr), .dp_wdata_i(dp_wdata),
    .dp_rdata_o(dp_rdata), .dp_done_o(dp_done),
    .rd_err_o(rd_err), .busy_o(busy),
    .mem_rw_o(mem_rw), .mem_clr_o(mem_clr), .mem_address_o(mem_address),
    .mem_data_in_o(mem_data_in), .mem_data_out_i(mem_data_out),
    .mem_out_valid_i(mem_out_valid)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Memory: writes/clears on posedge, read data returned rd_delay cycles after
  // the address is first presented; rd_delay==0 never answers.
  logic [DW-1:0] mem_tb [16];
  logic          mem_init;
  int            rd_delay;
  int            rd_cnt = 0;

  always @(posedge clk) begin
    if (mem_init)     for (int i = 0; i < 16; i++) mem_tb[i] <= DW'(i * 37 + 11);
    else if (mem_clr) for (int i = 0; i < 16; i++) mem_tb[i] <= '0;
    else if (mem_rw)  mem_tb[mem_address] <= mem_data_in;
  end

  always @(negedge clk) begin
    if (busy && !mem_rw && !mem_clr && !(clr_done || ld_done || if_done || dp_done))
      rd_cnt = rd_cnt + 1;
    else
      rd_cnt = 0;
    mem_out_valid = (rd_delay != 0) && (rd_cnt == rd_delay + 1);
    mem_data_out  = mem_out_valid ? mem_tb[mem_address] : DW'($urandom);
  end

  // Reference model state and per-cycle expectations for one round
  logic [DW-1:0] mem_ref [16];
  logic          m_last_dp;
  int            n_rep [4];
  logic [AW-1:0] f_addr [4][2];
  logic [DW-1:0] f_data [4][2];
  logic          f_we [2];

  logic [3:0]    e_done [NC];
  logic          e_busy [NC], e_rw [NC], e_clr [NC], e_chk_a [NC], e_rd [NC], e_err [NC];
  logic [AW-1:0] e_addr [NC];
  logic [DW-1:0] e_wdat [NC], e_rdat [NC];

  // Serve pending transactions one at a time from cycle 0 (all raised together,
  // each requester re-raising immediately until its reps are used up).
  task automatic build_model(output int last);
    int left [4];
    int rep [4];
    int f, w, r, d;
    logic rd;
    logic [AW-1:0] a;
    for (int k = 0; k < NC; k++) begin
      e_done[k] = '0; e_busy[k] = 0; e_rw[k] = 0; e_clr[k] = 0; e_chk_a[k] = 0;
      e_rd[k] = 0; e_err[k] = 0; e_addr[k] = '0; e_wdat[k] = '0; e_rdat[k] = '0;
    end
    for (int i = 0; i < 4; i++) begin left[i] = n_rep[i]; rep[i] = 0; end
    f = 0; last = 0;
    while (left[0] + left[1] + left[2] + left[3] > 0) begin
      if (left[0] > 0)                     w = 0;
      else if (left[1] > 0)                w = 1;
      else if (left[2] > 0 && left[3] > 0) w = m_last_dp ? 2 : 3;
      else if (left[2] > 0)                w = 2;
      else                                 w = 3;
      r  = rep[w];
      a  = f_addr[w][r];
      rd = (w == 2) || (w == 3 && !f_we[r]);
      if (w == 0) begin
        d = f + 2;
        e_clr[f+1] = 1;
        for (int i = 0; i < 16; i++) mem_ref[i] = '0;
      end else if (!rd) begin
        d = f + 2;
        e_rw[f+1] = 1; e_chk_a[f+1] = 1; e_addr[f+1] = a; e_wdat[f+1] = f_data[w][r];
        mem_ref[a] = f_data[w][r];
      end else begin
        d = (rd_delay == 0) ? f + 1 + RD_TIMEOUT : f + 2 + rd_delay;
        for (int k = f + 1; k < d; k++) begin e_chk_a[k] = 1; e_addr[k] = a; end
        e_rd[d]   = 1;
        e_err[d]  = (rd_delay == 0);
        e_rdat[d] = (rd_delay == 0) ? '0 : mem_ref[a];
      end
      if (w == 2) m_last_dp = 1'b0;
      if (w == 3) m_last_dp = 1'b1;
      for (int k = f + 1; k <= d; k++) e_busy[k] = 1;
      e_done[d] = 4'(1 << w);
      left[w]--; rep[w]++;
      f = d + 1; last = d;
    end
  endtask

  task automatic drive_req(input int w, input int r, input logic on);
    case (w)
      0: clr_req = on;
      1: begin ld_req = on; ld_addr = f_addr[1][r]; ld_wdata = f_data[1][r]; end
      2: begin if_req = on; if_addr = f_addr[2][r]; end
      default: begin
        dp_req = on; dp_we = f_we[r]; dp_addr = f_addr[3][r]; dp_wdata = f_data[3][r];
      end
    endcase
  endtask

  task automatic rand_fields();
    for (int i = 0; i < 4; i++)
      for (int r = 0; r < 2; r++) begin
        f_addr[i][r] = AW'($urandom);
        f_data[i][r] = DW'($urandom);
      end
    for (int r = 0; r < 2; r++) f_we[r] = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int w = 0; w < 4; w++) drive_req(w, 0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    m_last_dp = 1'b1;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_busy",  busy, 0);
    check_eq("rst_done",  {dp_done, if_done, ld_done, clr_done}, 0);
    check_eq("rst_rderr", rd_err, 0);
    check_eq("rst_memrw", mem_rw, 0);
    check_eq("rst_memclr", mem_clr, 0);
    check_eq("rst_addr",  mem_address, 0);
    check_eq("rst_din",   mem_data_in, 0);
    check_eq("rst_ifrd",  if_rdata, 0);
    check_eq("rst_dprd",  dp_rdata, 0);
  endtask

  task automatic run_round();
    int last;
    int rep [4];
    logic [3:0] dn;
    build_model(last);
    @(negedge clk);
    check_eq("idle_start", busy, 0);
    for (int w = 0; w < 4; w++) begin
      rep[w] = 0;
      if (n_rep[w] > 0) drive_req(w, 0, 1'b1);
    end
    for (int k = 1; k <= last + 2; k++) begin
      @(negedge clk);
      dn = {dp_done, if_done, ld_done, clr_done};
      check_eq("done_mask", dn, e_done[k]);
      check_eq("busy", busy, e_busy[k]);
      check_eq("mem_rw", mem_rw, e_rw[k]);
      check_eq("mem_clr", mem_clr, e_clr[k]);
      if (e_chk_a[k]) check_eq("mem_address", mem_address, e_addr[k]);
      if (e_rw[k])    check_eq("mem_data_in", mem_data_in, e_wdat[k]);
      if (e_rd[k]) begin
        check_eq("rd_err", rd_err, e_err[k]);
        if (e_done[k][2]) check_eq("if_rdata", if_rdata, e_rdat[k]);
        else              check_eq("dp_rdata", dp_rdata, e_rdat[k]);
      end
      for (int w = 0; w < 4; w++)
        if (dn[w] && rep[w] < n_rep[w]) begin
          rep[w]++;
          if (rep[w] < n_rep[w]) drive_req(w, rep[w], 1'b1);
          else                   drive_req(w, 0, 1'b0);
        end
    end
    for (int w = 0; w < 4; w++) drive_req(w, 0, 1'b0);
    if (busy) do_reset();
  endtask

  task automatic set_reps(input int c, input int l, input int i, input int d);
    n_rep[0] = c; n_rep[1] = l; n_rep[2] = i; n_rep[3] = d;
  endtask

  initial begin
    reset = 1'b1; mem_init = 1'b1; rd_delay = 1; m_last_dp = 1'b1;
    clr_req = 0; ld_req = 0; if_req = 0; dp_req = 0; dp_we = 0;
    ld_addr = '0; if_addr = '0; dp_addr = '0; ld_wdata = '0; dp_wdata = '0;
    for (int i = 0; i < 16; i++) mem_ref[i] = DW'(i * 37 + 11);
    rand_fields();
    repeat (2) @(negedge clk);
    reset = 1'b0; mem_init = 1'b0;
    check_reset_outputs();

    // Loader write 5A to address 3, then fetch it back with a 1-cycle memory
    rand_fields(); set_reps(0, 1, 0, 0);
    f_addr[1][0] = 4'd3; f_data[1][0] = 8'h5A;
    run_round();
    rand_fields(); set_reps(0, 0, 1, 0);
    f_addr[2][0] = 4'd3; rd_delay = 1;
    run_round();

    // Fetch and data-path reads competing continuously alternate if,dp,if,dp
    do_reset();
    check_reset_outputs();
    rand_fields(); set_reps(0, 0, 2, 2);
    f_we[0] = 1'b0; f_we[1] = 1'b0; rd_delay = 2;
    run_round();

    // Clear beats a simultaneous loader write
    rand_fields(); set_reps(1, 1, 0, 0);
    run_round();

    // Data-path read that the memory never answers
    rand_fields(); set_reps(0, 0, 0, 1);
    f_we[0] = 1'b0; rd_delay = 0;
    run_round();

    // Reset while a read is waiting aborts it silently
    rand_fields(); f_we[0] = 1'b0; rd_delay = 0;
    @(negedge clk);
    drive_req(3, 0, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("t6_busy_pre", busy, 1);
    reset = 1'b1;
    drive_req(3, 0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    m_last_dp = 1'b1;
    check_reset_outputs();
    repeat (3) begin
      @(negedge clk);
      check_eq("t6_no_done", {dp_done, if_done, ld_done, clr_done}, 0);
      check_eq("t6_idle", busy, 0);
    end

    // Random mixes of simultaneous requests and memory latencies
    for (int n = 0; n < 40; n++) begin
      rand_fields();
      set_reps(($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 2),
               $urandom_range(0, 2), $urandom_range(0, 2));
      if (n_rep[0] + n_rep[1] + n_rep[2] + n_rep[3] == 0) n_rep[3] = 1;
      rd_delay = $urandom_range(0, 3);
      run_round();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
